// File: rtl/countdown_timer_amisha_pkg.sv
// Shared definitions for the countdown timer and its stopwatch sibling:
// state encodings, default prescaler divisor and BCD helpers.
package countdown_timer_amisha_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int         DVSR_DEFAULT = 5000000;
  localparam logic [3:0] BCD_MAX      = 4'd9;

  // Out-of-range preset digits saturate to the largest legal BCD value.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] digit);
    logic [3:0] result;
    if (digit > BCD_MAX) begin
      result = BCD_MAX;
    end else begin
      result = digit;
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_dec_digit_amisha.sv
// One BCD digit of a down-counter; digits chain through borrow_in/borrow_out.
module bcd_dec_digit_amisha
  import countdown_timer_amisha_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       borrow_in,
  output logic [3:0] digit_next,
  output logic       borrow_out
);

  // Decrement with 0 -> 9 wrap; the wrap is what generates the borrow.
  always_comb begin
    digit_next = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == 4'd0) begin
        digit_next = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        digit_next = digit - 4'd1;
        borrow_out = 1'b0;
      end
    end else begin
      digit_next = digit;
      borrow_out = 1'b0;
    end
  end

endmodule

// File: rtl/countdown_timer_amisha.sv
// Three-digit BCD countdown timer (00.0 .. 99.9 s) with 0.1 s prescaler,
// pause/resume and a one-cycle expiry pulse.
module countdown_timer_amisha
  import countdown_timer_amisha_pkg::*;
#(
  parameter int DVSR = DVSR_DEFAULT,
  parameter int MS_W = 23
) (
  input  logic       clk_amisha,
  input  logic       reset_amisha,
  input  logic       load_amisha,
  input  logic       start_amisha,
  input  logic       stop_amisha,
  input  logic [3:0] p2_amisha,
  input  logic [3:0] p1_amisha,
  input  logic [3:0] p0_amisha,
  output logic [3:0] d2_amisha,
  output logic [3:0] d1_amisha,
  output logic [3:0] d0_amisha,
  output logic       running_amisha,
  output logic       expired_amisha,
  output logic       done_tick_amisha
);

  state_t            state_r, state_next_s;
  logic [MS_W-1:0]   ms_r, ms_next_s;
  logic [3:0]        d2_r, d1_r, d0_r;
  logic [3:0]        d2_next_s, d1_next_s, d0_next_s;
  logic              running_r, expired_r, done_tick_r;
  logic              done_next_s;

  logic [3:0]        nd2_s, nd1_s, nd0_s;
  logic              borrow0_s, borrow1_s, borrow2_s;
  logic              ms_last_s, tick_s, digits_zero_s, next_zero_s;

  // Borrow chain: tenths always decrements, higher digits follow the borrow.
  bcd_dec_digit_amisha u_dig0 (
    .digit      (d0_r),
    .borrow_in  (1'b1),
    .digit_next (nd0_s),
    .borrow_out (borrow0_s)
  );

  bcd_dec_digit_amisha u_dig1 (
    .digit      (d1_r),
    .borrow_in  (borrow0_s),
    .digit_next (nd1_s),
    .borrow_out (borrow1_s)
  );

  bcd_dec_digit_amisha u_dig2 (
    .digit      (d2_r),
    .borrow_in  (borrow1_s),
    .digit_next (nd2_s),
    .borrow_out (borrow2_s)
  );

  assign ms_last_s     = (ms_r == MS_W'(DVSR - 1));
  assign tick_s        = (state_r == ST_RUN) && ms_last_s && !load_amisha && !stop_amisha;
  assign digits_zero_s = (d2_r == 4'd0) && (d1_r == 4'd0) && (d0_r == 4'd0);
  assign next_zero_s   = (nd2_s == 4'd0) && (nd1_s == 4'd0) && (nd0_s == 4'd0);

  // Next-state, prescaler and digit logic with priority load > stop > start.
  always_comb begin
    state_next_s = state_r;
    ms_next_s    = ms_r;
    d2_next_s    = d2_r;
    d1_next_s    = d1_r;
    d0_next_s    = d0_r;
    done_next_s  = 1'b0;
    if (load_amisha) begin
      d2_next_s    = clamp_bcd(p2_amisha);
      d1_next_s    = clamp_bcd(p1_amisha);
      d0_next_s    = clamp_bcd(p0_amisha);
      ms_next_s    = {MS_W{1'b0}};
      state_next_s = ST_IDLE;
    end else if (stop_amisha) begin
      if (state_r == ST_RUN) begin
        state_next_s = ST_PAUSE;
      end else begin
        state_next_s = state_r;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_amisha && !digits_zero_s) begin
            state_next_s = ST_RUN;
            ms_next_s    = {MS_W{1'b0}};
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (ms_last_s) begin
            ms_next_s = {MS_W{1'b0}};
          end else begin
            ms_next_s = ms_r + MS_W'(1);
          end
          // A borrow out of the top digit would mean wrapping below 00.0.
          if (tick_s && !borrow2_s) begin
            d2_next_s = nd2_s;
            d1_next_s = nd1_s;
            d0_next_s = nd0_s;
            if (next_zero_s) begin
              state_next_s = ST_DONE;
              done_next_s  = 1'b1;
            end else begin
              state_next_s = ST_RUN;
            end
          end else begin
            state_next_s = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (start_amisha) begin
            state_next_s = ST_RUN;
          end else begin
            state_next_s = ST_PAUSE;
          end
        end
        ST_DONE: begin
          state_next_s = ST_DONE;
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, prescaler, digits and decoded status flags.
  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      state_r     <= ST_IDLE;
      ms_r        <= {MS_W{1'b0}};
      d2_r        <= 4'd0;
      d1_r        <= 4'd0;
      d0_r        <= 4'd0;
      running_r   <= 1'b0;
      expired_r   <= 1'b0;
      done_tick_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      ms_r        <= ms_next_s;
      d2_r        <= d2_next_s;
      d1_r        <= d1_next_s;
      d0_r        <= d0_next_s;
      running_r   <= (state_next_s == ST_RUN);
      expired_r   <= (state_next_s == ST_DONE);
      done_tick_r <= done_next_s;
    end
  end

  assign d2_amisha        = d2_r;
  assign d1_amisha        = d1_r;
  assign d0_amisha        = d0_r;
  assign running_amisha   = running_r;
  assign expired_amisha   = expired_r;
  assign done_tick_amisha = done_tick_r;

endmodule

// File: tb/tb_countdown_timer_amisha.sv
// Directed bench for countdown_timer_amisha with DVSR=4.
module tb_countdown_timer_amisha;

  logic       clk_amisha = 1'b0;
  logic       reset_amisha = 1'b0;
  logic       load_amisha = 1'b0;
  logic       start_amisha = 1'b0;
  logic       stop_amisha = 1'b0;
  logic [3:0] p2_amisha = 4'd0;
  logic [3:0] p1_amisha = 4'd0;
  logic [3:0] p0_amisha = 4'd0;
  logic [3:0] d2_amisha, d1_amisha, d0_amisha;
  logic       running_amisha, expired_amisha, done_tick_amisha;

  int checks = 0;
  int errors = 0;

  countdown_timer_amisha #(.DVSR(4), .MS_W(3)) dut (
    .clk_amisha       (clk_amisha),
    .reset_amisha     (reset_amisha),
    .load_amisha      (load_amisha),
    .start_amisha     (start_amisha),
    .stop_amisha      (stop_amisha),
    .p2_amisha        (p2_amisha),
    .p1_amisha        (p1_amisha),
    .p0_amisha        (p0_amisha),
    .d2_amisha        (d2_amisha),
    .d1_amisha        (d1_amisha),
    .d0_amisha        (d0_amisha),
    .running_amisha   (running_amisha),
    .expired_amisha   (expired_amisha),
    .done_tick_amisha (done_tick_amisha)
  );

  always #5 clk_amisha = ~clk_amisha;

  function automatic logic [11:0] digits_of(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_amisha);
      #1;
    end
  endtask

  task automatic do_load(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    p2_amisha = a; p1_amisha = b; p0_amisha = c;
    load_amisha = 1'b1;
    step(1);
    load_amisha = 1'b0;
  endtask

  task automatic do_start();
    start_amisha = 1'b1;
    step(1);
    start_amisha = 1'b0;
  endtask

  task automatic test_reset();
    reset_amisha = 1'b1;
    load_amisha = 1'b1;
    p2_amisha = 4'd5; p1_amisha = 4'd5; p0_amisha = 4'd5;
    step(2);
    reset_amisha = 1'b0;
    load_amisha = 1'b0;
    checks++;
    if ({d2_amisha, d1_amisha, d0_amisha} !== 12'h000) begin
      errors++;
      $display("FAIL reset_digits got %h want 000", {d2_amisha, d1_amisha, d0_amisha});
    end
    checks++;
    if ({running_amisha, expired_amisha, done_tick_amisha} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b want 000", {running_amisha, expired_amisha, done_tick_amisha});
    end
  endtask

  task automatic test_basic();
    do_load(4'd0, 4'd1, 4'd2);
    checks++;
    if ({d2_amisha, d1_amisha, d0_amisha, running_amisha} !== {12'h012, 1'b0}) begin
      errors++;
      $display("FAIL load_012 got %h run %b want 012 run 0", {d2_amisha, d1_amisha, d0_amisha}, running_amisha);
    end
    do_start();
    checks++;
    if (running_amisha !== 1'b1) begin
      errors++;
      $display("FAIL start_running got %b want 1", running_amisha);
    end
    step(3);
    checks++;
    if ({d2_amisha, d1_amisha, d0_amisha} !== 12'h012) begin
      errors++;
      $display("FAIL edge3 got %h want 012", {d2_amisha, d1_amisha, d0_amisha});
    end
    step(1);
    checks++;
    if ({d2_amisha, d1_amisha, d0_amisha} !== 12'h011) begin
      errors++;
      $display("FAIL edge4 got %h want 011", {d2_amisha, d1_amisha, d0_amisha});
    end
    step(4);
    checks++;
    if ({d2_amisha, d1_amisha, d0_amisha} !== 12'h010) begin
      errors++;
      $display("FAIL edge8 got %h want 010", {d2_amisha, d1_amisha, d0_amisha});
    end
    step(39);
    checks++;
    if ({d2_amisha, d1_amisha, d0_amisha, done_tick_amisha} !== {12'h001, 1'b0}) begin
      errors++;
      $display("FAIL edge47 got %h done %b want 001 done 0", {d2_amisha, d1_amisha, d0_amisha}, done_tick_amisha);
    end
    step(1);
    checks++;
    if ({d2_amisha, d1_amisha, d0_amisha, done_tick_amisha, expired_amisha, running_amisha} !== {12'h000, 3'b110}) begin
      errors++;
      $display("FAIL edge48 got %h done %b exp %b run %b want 000 1 1 0",
               {d2_amisha, d1_amisha, d0_amisha}, done_tick_amisha, expired_amisha, running_amisha);
    end
    step(1);
    checks++;
    if ({done_tick_amisha, expired_amisha} !== 2'b01) begin
      errors++;
      $display("FAIL done_pulse_end got done %b exp %b want 0 1", done_tick_amisha, expired_amisha);
    end
    do_start();
    step(5);
    checks++;
    if ({d2_amisha, d1_amisha, d0_amisha, expired_amisha, running_amisha, done_tick_amisha} !== {12'h000, 3'b100}) begin
      errors++;
      $display("FAIL start_in_done got %h exp %b run %b done %b want 000 1 0 0",
               {d2_amisha, d1_amisha, d0_amisha}, expired_amisha, running_amisha, done_tick_amisha);
    end
  endtask

  task automatic test_borrow();
    int pulses;
    do_load(4'd1, 4'd0, 4'd0);
    do_start();
    step(4);
    checks++;
    if ({d2_amisha, d1_amisha, d0_amisha} !== 12'h099) begin
      errors++;
      $display("FAIL borrow_100 got %h want 099", {d2_amisha, d1_amisha, d0_amisha});
    end
    do_load(4'd9, 4'd9, 4'd9);
    do_start();
    pulses = 0;
    for (int v = 998; v >= 0; v--) begin
      for (int e = 0; e < 4; e++) begin
        step(1);
        if (done_tick_amisha === 1'b1) pulses++;
      end
      checks++;
      if ({d2_amisha, d1_amisha, d0_amisha} !== digits_of(v)) begin
        errors++;
        $display("FAIL count_999 got %h want %h", {d2_amisha, d1_amisha, d0_amisha}, digits_of(v));
      end
    end
    step(12);
    checks++;
    if ({d2_amisha, d1_amisha, d0_amisha, expired_amisha} !== {12'h000, 1'b1}) begin
      errors++;
      $display("FAIL no_wrap got %h exp %b want 000 1", {d2_amisha, d1_amisha, d0_amisha}, expired_amisha);
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL done_pulse_count got %0d want 1", pulses);
    end
  endtask

  task automatic test_pause();
    do_load(4'd0, 4'd1, 4'd2);
    do_start();
    step(6);
    checks++;
    if ({d2_amisha, d1_amisha, d0_amisha} !== 12'h011) begin
      errors++;
      $display("FAIL pause_pre got %h want 011", {d2_amisha, d1_amisha, d0_amisha});
    end
    stop_amisha = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      checks++;
      if ({d2_amisha, d1_amisha, d0_amisha, running_amisha} !== {12'h011, 1'b0}) begin
        errors++;
        $display("FAIL pause_hold got %h run %b want 011 run 0", {d2_amisha, d1_amisha, d0_amisha}, running_amisha);
      end
    end
    stop_amisha = 1'b0;
    do_start();
    checks++;
    if ({d2_amisha, d1_amisha, d0_amisha, running_amisha} !== {12'h011, 1'b1}) begin
      errors++;
      $display("FAIL resume got %h run %b want 011 run 1", {d2_amisha, d1_amisha, d0_amisha}, running_amisha);
    end
    step(1);
    checks++;
    if ({d2_amisha, d1_amisha, d0_amisha} !== 12'h011) begin
      errors++;
      $display("FAIL resume_e1 got %h want 011", {d2_amisha, d1_amisha, d0_amisha});
    end
    step(1);
    checks++;
    if ({d2_amisha, d1_amisha, d0_amisha} !== 12'h010) begin
      errors++;
      $display("FAIL resume_e2 got %h want 010", {d2_amisha, d1_amisha, d0_amisha});
    end
  endtask

  task automatic test_zero_and_clamp();
    int pulses;
    do_load(4'd0, 4'd0, 4'd0);
    start_amisha = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (done_tick_amisha === 1'b1) pulses++;
    end
    start_amisha = 1'b0;
    checks++;
    if ({running_amisha, expired_amisha, pulses[0]} !== 3'b000 || pulses != 0) begin
      errors++;
      $display("FAIL zero_start got run %b exp %b pulses %0d want 0 0 0", running_amisha, expired_amisha, pulses);
    end
    do_load(4'd0, 4'd0, 4'hC);
    checks++;
    if ({d2_amisha, d1_amisha, d0_amisha} !== 12'h009) begin
      errors++;
      $display("FAIL clamp_p0 got %h want 009", {d2_amisha, d1_amisha, d0_amisha});
    end
    do_load(4'hF, 4'hA, 4'd3);
    checks++;
    if ({d2_amisha, d1_amisha, d0_amisha} !== 12'h993) begin
      errors++;
      $display("FAIL clamp_hi got %h want 993", {d2_amisha, d1_amisha, d0_amisha});
    end
  endtask

  task automatic test_simultaneous();
    do_load(4'd0, 4'd1, 4'd2);
    do_start();
    step(2);
    start_amisha = 1'b1;
    stop_amisha = 1'b1;
    step(1);
    start_amisha = 1'b0;
    stop_amisha = 1'b0;
    step(4);
    checks++;
    if ({d2_amisha, d1_amisha, d0_amisha, running_amisha} !== {12'h012, 1'b0}) begin
      errors++;
      $display("FAIL start_stop got %h run %b want 012 run 0", {d2_amisha, d1_amisha, d0_amisha}, running_amisha);
    end
    do_start();
    step(1);
    do_load(4'd3, 4'd4, 4'd5);
    checks++;
    if ({d2_amisha, d1_amisha, d0_amisha, running_amisha} !== {12'h345, 1'b0}) begin
      errors++;
      $display("FAIL load_in_run got %h run %b want 345 run 0", {d2_amisha, d1_amisha, d0_amisha}, running_amisha);
    end
    do_start();
    step(3);
    checks++;
    if ({d2_amisha, d1_amisha, d0_amisha} !== 12'h345) begin
      errors++;
      $display("FAIL reload_e3 got %h want 345", {d2_amisha, d1_amisha, d0_amisha});
    end
    step(1);
    checks++;
    if ({d2_amisha, d1_amisha, d0_amisha} !== 12'h344) begin
      errors++;
      $display("FAIL reload_e4 got %h want 344", {d2_amisha, d1_amisha, d0_amisha});
    end
  endtask

  task automatic test_reset_mid();
    do_load(4'd0, 4'd1, 4'd2);
    do_start();
    step(20);
    checks++;
    if ({d2_amisha, d1_amisha, d0_amisha} !== 12'h007) begin
      errors++;
      $display("FAIL mid_007 got %h want 007", {d2_amisha, d1_amisha, d0_amisha});
    end
    reset_amisha = 1'b1;
    step(1);
    reset_amisha = 1'b0;
    checks++;
    if ({d2_amisha, d1_amisha, d0_amisha, running_amisha, expired_amisha, done_tick_amisha} !== 15'h0) begin
      errors++;
      $display("FAIL mid_reset got %h flags %b want 000 000",
               {d2_amisha, d1_amisha, d0_amisha}, {running_amisha, expired_amisha, done_tick_amisha});
    end
    do_start();
    step(8);
    checks++;
    if ({d2_amisha, d1_amisha, d0_amisha, running_amisha, done_tick_amisha} !== 14'h0) begin
      errors++;
      $display("FAIL start_after_reset got %h run %b done %b want 000 0 0",
               {d2_amisha, d1_amisha, d0_amisha}, running_amisha, done_tick_amisha);
    end
    do_load(4'd0, 4'd0, 4'd1);
    do_start();
    step(4);
    checks++;
    if ({d2_amisha, d1_amisha, d0_amisha, done_tick_amisha, expired_amisha} !== {12'h000, 2'b11}) begin
      errors++;
      $display("FAIL recover_001 got %h done %b exp %b want 000 1 1",
               {d2_amisha, d1_amisha, d0_amisha}, done_tick_amisha, expired_amisha);
    end
  endtask

  initial begin
    step(1);
    test_reset();
    test_basic();
    test_borrow();
    test_pause();
    test_zero_and_clamp();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
